mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access unit between the EX/MEM pipeline register and `data_memory`; drives the word-only memory port and registers results into MEM/WB. Adds byte/halfword loads with sign/zero extension, byte/halfword stores via a two-cycle registered read-modify-write, misalignment detection, and the MEM/WB register with flush.

## Interface
- `SIZE_B`, 2'b00: byte access encoding
- `SIZE_H`, 2'b01: halfword access encoding
- `SIZE_W`, 2'b10: word access encoding
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  EX/MEM holds a valid instruction
- `in_read`  in  1  load
- `in_write`  in  1  store
- `in_size`  in  2  access size
- `in_unsigned`  in  1  zero-extend load
- `in_addr`  in  32  byte address (ALU result)
- `in_wdata`  in  32  store data, right-aligned
- `in_rd`  in  5  destination register
- `in_reg_write`  in  1  instruction writes rd (non-load: `in_addr` is the result)
- `flush`  in  1  drop the instruction presented this cycle
- `stall`  out  1  upstream must hold EX/MEM
- `dm_write`  out  1  to data_memory `write`
- `dm_address`  out  32  to data_memory `address`, always word-aligned
- `dm_write_data`  out  32  to data_memory `write_data`
- `dm_read_data`  in  32  from data_memory `read_data` (combinational read)
- `wb_valid`, `wb_reg_write`  out  1  MEM/WB valid, register write enable
- `wb_rd`  out  5, `wb_data`  out  32  MEM/WB destination and result
- `misalign_err`  out  1  one-cycle pulse on misaligned access
- `misalign_addr`  out  32  captured faulting address

## Operation
- States: IDLE, MERGE. Accept = `in_valid & ~flush & state==IDLE`.
- `dm_address` = {in_addr[31:2],2'b00} in IDLE; {cap_addr[31:2],2'b00} in MERGE.
- Misaligned: H with addr[0]=1; W with addr[1:0]!=0. Access suppressed (no dm_write), `misalign_err`=1 next cycle, `misalign_addr` updated, `wb_valid`=0 next cycle. Byte never misaligned.
- Load: lane = addr[1:0] (little-endian); byte = word>>(8*lane), half = word>>(16*addr[1]); sign-extend unless `in_unsigned`. Result to `wb_data`.
- Word store: `dm_write`=1, `dm_write_data`=`in_wdata` same cycle; stays IDLE.
- Sub-word store, IDLE: capture address, size, merged word = `dm_read_data` with target lane(s) replaced by `in_wdata` low bits; `dm_write`=0; go MERGE.
- MERGE: `dm_write`=1, `dm_write_data`=merged register, `stall`=1; go IDLE next cycle. `flush` ignored in MERGE (store already committed).
- `stall` = (state==MERGE), purely from state register.
- Non-memory instruction: `wb_data`=`in_addr`.
- Conflicting `in_read & in_write`: treated as store.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE; `wb_valid`, `wb_reg_write`, `misalign_err`=0; `wb_rd`=0, `wb_data`=0, `misalign_addr`=0, merge register 0. `dm_write`=0 during reset.
- Load/ALU/word store: MEM/WB updates at next edge, latency 1, no bubble.
- Sub-word store: accept cycle N, memory written at edge ending N+1, `stall`=1 in N+1; next instruction accepted N+2. `wb_valid`=1 (reg_write=0) at N+2 for the store; bubble (`wb_valid`=0) at N+1.
- Flush in IDLE: `wb_valid`=0 next cycle, no memory write.
- Reset in MERGE: `dm_write` drops immediately, write lost, memory unchanged.

## Structure
- Shared package `mem_pkg`: size encodings, state encodings, lane-mask function.
- Sub-module `store_merge` (combinational: word, wdata, size, lane -> merged word); load extraction inline.

## Test plan
- Word store 0xDEADBEEF @0x20, then LW @0x20 -> `dm_write`=1 one cycle, next-cycle `wb_data`=0xDEADBEEF, `stall` never high.
- Word @0x20=0x11223344; SB 0xAB @0x21 -> `stall`=1 exactly one cycle, memory word 0x1122AB44; LBU @0x21 -> 0x000000AB.
- Word @0x30=0x80FF0000; LB @0x33 -> 0xFFFFFF80; LBU @0x33 -> 0x00000080; LH @0x32 -> 0xFFFF80FF.
- LH @0x05 -> `misalign_err`=1 one cycle, `misalign_addr`=0x05, `wb_valid`=0; SW @0x06 -> `dm_write` never asserted.
- SW with `flush`=1 -> no write, `wb_valid`=0; SH 0x1234 @0x42 with `flush` raised in MERGE -> write completes, upper half 0x1234.
- `reset` low during MERGE -> `dm_write`=0 immediately, all outputs at reset values, memory unchanged, `stall`=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access unit: access sizes, FSM states
// and the byte-lane mask helper used by the store merge logic.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MERGE = 1'b1;

  // One bit per byte lane that the access touches (little-endian lanes).
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001 << lane;
      SIZE_H:  mask = lane[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_unit_store_merge.sv
// Combinational merge of right-aligned store data into the word read back
// from memory, replacing only the byte lanes the store targets.
module store_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged
);

  logic [3:0]  w_mask;
  logic [31:0] w_rep;
  logic [31:0] w_merged;

  // Replicating the data puts the right bytes in every candidate lane.
  always_comb begin
    w_mask = lane_mask(i_size, i_lane);
    case (i_size)
      SIZE_B:  w_rep = {4{i_wdata[7:0]}};
      SIZE_H:  w_rep = {2{i_wdata[15:0]}};
      default: w_rep = i_wdata;
    endcase
    w_merged = i_word;
    for (int i = 0; i < 4; i++) begin
      if (w_mask[i]) w_merged[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

  assign o_merged = w_merged;

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives the word-only data memory port, handles
// sub-word loads/stores (stores via a two-cycle read-modify-write) and MEM/WB.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        flush,
  output logic        stall,
  output logic        dm_write,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic [31:0] misalign_addr
);

  logic [0:0]  r_state;
  logic [29:0] r_cap_addr;
  logic [31:0] r_merge;
  logic        r_wb_valid;
  logic        r_wb_reg_write;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misalign_err;
  logic [31:0] r_misalign_addr;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_word_store;
  logic        w_sub_store;
  logic        w_retire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_result;
  logic [31:0] w_merged;

  assign w_accept     = in_valid & ~flush & (r_state == ST_IDLE);
  assign w_is_mem     = in_read | in_write;
  assign w_misalign   = w_is_mem & (((in_size == SIZE_H) & in_addr[0]) |
                                    ((in_size == SIZE_W) & (in_addr[1:0] != 2'b00)));
  assign w_word_store = w_accept & in_write & ~w_misalign & (in_size == SIZE_W);
  assign w_sub_store  = w_accept & in_write & ~w_misalign & (in_size != SIZE_W);
  assign w_retire     = w_accept & ~w_misalign & ~w_sub_store;

  always_comb begin
    case (in_addr[1:0])
      2'd0:    w_byte = dm_read_data[7:0];
      2'd1:    w_byte = dm_read_data[15:8];
      2'd2:    w_byte = dm_read_data[23:16];
      default: w_byte = dm_read_data[31:24];
    endcase
    w_half = in_addr[1] ? dm_read_data[31:16] : dm_read_data[15:0];
    case (in_size)
      SIZE_B:  w_load = in_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_H:  w_load = in_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = dm_read_data;
    endcase
    w_result = (in_read & ~in_write) ? w_load : in_addr;
  end

  store_merge u_store_merge (
    .i_word   (dm_read_data),
    .i_wdata  (in_wdata),
    .i_size   (in_size),
    .i_lane   (in_addr[1:0]),
    .o_merged (w_merged)
  );

  // Gating with reset drops a pending merge write the instant reset asserts.
  assign dm_write      = reset & ((r_state == ST_MERGE) | w_word_store);
  assign dm_address    = (r_state == ST_MERGE) ? {r_cap_addr, 2'b00} : {in_addr[31:2], 2'b00};
  assign dm_write_data = (r_state == ST_MERGE) ? r_merge : in_wdata;
  assign stall         = (r_state == ST_MERGE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_cap_addr      <= 30'd0;
      r_merge         <= 32'd0;
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_rd         <= 5'd0;
      r_wb_data       <= 32'd0;
      r_misalign_err  <= 1'b0;
      r_misalign_addr <= 32'd0;
    end else begin
      r_misalign_err <= w_accept & w_misalign;
      if (w_accept & w_misalign) r_misalign_addr <= in_addr;
      if (r_state == ST_MERGE) begin
        r_state        <= ST_IDLE;
        r_wb_valid     <= 1'b1;
        r_wb_reg_write <= 1'b0;
      end else begin
        r_wb_valid     <= w_retire;
        r_wb_reg_write <= w_retire & in_reg_write & ~in_write;
        if (w_accept & ~w_misalign) begin
          r_wb_rd   <= in_rd;
          r_wb_data <= w_result;
        end
        if (w_sub_store) begin
          r_state    <= ST_MERGE;
          r_cap_addr <= in_addr[31:2];
          r_merge    <= w_merged;
        end
      end
    end
  end

  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign misalign_err  = r_misalign_err;
  assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        in_valid, in_read, in_write, in_unsigned, in_reg_write, flush;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        stall, dm_write, wb_valid, wb_reg_write, misalign_err;
  logic [31:0] dm_address, dm_write_data, wb_data, misalign_addr;
  logic [4:0]  wb_rd;
  wire  [31:0] dm_read_data;

  logic [31:0] mem    [64];
  logic [31:0] refMem [64];

  int checks = 0;
  int fails  = 0;

  mem_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_read       (in_read),
    .in_write      (in_write),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .flush         (flush),
    .stall         (stall),
    .dm_write      (dm_write),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_read_data = mem[dm_address[7:2]];

  always @(posedge clk) begin
    if (dm_write) mem[dm_address[7:2]] <= dm_write_data;
  end

  function automatic logic [31:0] refLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    logic [31:0] w;
    logic [31:0] v;
    w = refMem[addr[7:2]];
    if (sz == 2'd0) begin
      v = (w >> (8 * addr[1:0])) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (addr[1:0] / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic refStore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
    int nb;
    int pos;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) begin
      pos = int'(addr % 4) + i;
      refMem[addr[7:2]] = (refMem[addr[7:2]] & ~(32'hFF << (8 * pos))) |
                          (((data >> (8 * i)) & 32'hFF) << (8 * pos));
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx]    = val;
    refMem[idx] = val;
  endtask

  task automatic setIdle;
    in_valid = 0; in_read = 0; in_write = 0; in_size = 2'd0; in_unsigned = 0;
    in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; in_reg_write = 0; flush = 0;
  endtask

  task automatic present(input logic rdI, input logic wrI, input logic [1:0] szI, input logic unsI,
                         input logic [31:0] addrI, input logic [31:0] wdI, input logic [4:0] rdReg,
                         input logic regW, input logic flI);
    in_valid = 1; in_read = rdI; in_write = wrI; in_size = szI; in_unsigned = unsI;
    in_addr = addrI; in_wdata = wdI; in_rd = rdReg; in_reg_write = regW; flush = flI;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 0;
    setIdle();
    #2;
    checks++;
    if ({stall, dm_write, wb_valid, wb_reg_write, misalign_err} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags got %b want 00000", {stall, dm_write, wb_valid, wb_reg_write, misalign_err});
    end
    checks++;
    if (wb_rd !== 5'd0 || wb_data !== 32'd0 || misalign_addr !== 32'd0) begin
      fails++; $display("[TB] FAIL reset_values got rd=%0d data=%h maddr=%h want zeros", wb_rd, wb_data, misalign_addr);
    end
    present(0, 1, 2'd2, 0, 32'h10, 32'h12345678, 5'd0, 0, 0);
    #1;
    checks++;
    if (dm_write !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_dm_write got %b want 0", dm_write);
    end
    setIdle();
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_word_store_load;
    present(0, 1, 2'd2, 0, 32'h20, 32'hDEADBEEF, 5'd3, 0, 0);
    #1;
    checks++;
    if (dm_write !== 1'b1 || dm_address !== 32'h20 || dm_write_data !== 32'hDEADBEEF || stall !== 1'b0) begin
      fails++; $display("[TB] FAIL sw_port got we=%b a=%h d=%h st=%b want 1/20/deadbeef/0", dm_write, dm_address, dm_write_data, stall);
    end
    refStore(32'h20, 2'd2, 32'hDEADBEEF);
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || stall !== 1'b0 || mem[8] !== refMem[8]) begin
      fails++; $display("[TB] FAIL sw_commit got v=%b rw=%b st=%b mem=%h want 1/0/0/%h", wb_valid, wb_reg_write, stall, mem[8], refMem[8]);
    end
    present(1, 0, 2'd2, 0, 32'h20, 32'h0, 5'd5, 1, 0);
    #1;
    checks++;
    if (dm_write !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("[TB] FAIL lw_port got we=%b st=%b want 0/0", dm_write, stall);
    end
    tick();
    setIdle();
    checks++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL lw_result got v=%b rw=%b rd=%0d d=%h want 1/1/5/deadbeef", wb_valid, wb_reg_write, wb_rd, wb_data);
    end
  endtask

  task automatic test_subword_store;
    preload(8, 32'h11223344);
    present(0, 1, 2'd0, 0, 32'h21, 32'hFFFFFFAB, 5'd0, 0, 0);
    #1;
    checks++;
    if (dm_write !== 1'b0 || stall !== 1'b0) begin
      fails++; $display("[TB] FAIL sb_accept got we=%b st=%b want 0/0", dm_write, stall);
    end
    refStore(32'h21, 2'd0, 32'hFFFFFFAB);
    tick();
    present(1, 0, 2'd0, 1, 32'h21, 32'h0, 5'd7, 1, 0);
    #1;
    checks++;
    if (stall !== 1'b1 || dm_write !== 1'b1 || dm_address !== 32'h20 || dm_write_data !== 32'h1122AB44 || wb_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL sb_merge got st=%b we=%b a=%h d=%h v=%b want 1/1/20/1122ab44/0", stall, dm_write, dm_address, dm_write_data, wb_valid);
    end
    tick();
    #1;
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || mem[8] !== refMem[8]) begin
      fails++; $display("[TB] FAIL sb_done got st=%b v=%b rw=%b mem=%h want 0/1/0/%h", stall, wb_valid, wb_reg_write, mem[8], refMem[8]);
    end
    @(negedge clk);
    setIdle();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h000000AB) begin
      fails++; $display("[TB] FAIL lbu_after_sb got v=%b rd=%0d d=%h want 1/7/000000ab", wb_valid, wb_rd, wb_data);
    end
  endtask

  task automatic test_load_extension;
    preload(12, 32'h80FF0000);
    present(1, 0, 2'd0, 0, 32'h33, 32'h0, 5'd1, 1, 0);
    tick();
    checks++;
    if (wb_data !== 32'hFFFFFF80) begin
      fails++; $display("[TB] FAIL lb_sign got %h want ffffff80", wb_data);
    end
    present(1, 0, 2'd0, 1, 32'h33, 32'h0, 5'd2, 1, 0);
    tick();
    checks++;
    if (wb_data !== 32'h00000080) begin
      fails++; $display("[TB] FAIL lbu_zero got %h want 00000080", wb_data);
    end
    present(1, 0, 2'd1, 0, 32'h32, 32'h0, 5'd3, 1, 0);
    tick();
    setIdle();
    checks++;
    if (wb_data !== 32'hFFFF80FF || wb_valid !== 1'b1) begin
      fails++; $display("[TB] FAIL lh_sign got d=%h v=%b want ffff80ff/1", wb_data, wb_valid);
    end
  endtask

  task automatic test_misalign;
    present(1, 0, 2'd1, 0, 32'h05, 32'h0, 5'd4, 1, 0);
    #1;
    checks++;
    if (dm_write !== 1'b0) begin
      fails++; $display("[TB] FAIL lh_mis_we got %b want 0", dm_write);
    end
    tick();
    setIdle();
    checks++;
    if (misalign_err !== 1'b1 || misalign_addr !== 32'h05 || wb_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL lh_mis got err=%b a=%h v=%b want 1/05/0", misalign_err, misalign_addr, wb_valid);
    end
    tick();
    checks++;
    if (misalign_err !== 1'b0 || misalign_addr !== 32'h05) begin
      fails++; $display("[TB] FAIL mis_pulse got err=%b a=%h want 0/05", misalign_err, misalign_addr);
    end
    present(0, 1, 2'd2, 0, 32'h06, 32'hCAFEF00D, 5'd0, 0, 0);
    #1;
    checks++;
    if (dm_write !== 1'b0) begin
      fails++; $display("[TB] FAIL sw_mis_we got %b want 0", dm_write);
    end
    tick();
    setIdle();
    checks++;
    if (misalign_err !== 1'b1 || misalign_addr !== 32'h06 || wb_valid !== 1'b0 || mem[1] !== refMem[1]) begin
      fails++; $display("[TB] FAIL sw_mis got err=%b a=%h v=%b mem=%h want 1/06/0/%h", misalign_err, misalign_addr, wb_valid, mem[1], refMem[1]);
    end
  endtask

  task automatic test_flush;
    preload(9, 32'h01020304);
    present(0, 1, 2'd2, 0, 32'h24, 32'h99999999, 5'd0, 0, 1);
    #1;
    checks++;
    if (dm_write !== 1'b0) begin
      fails++; $display("[TB] FAIL flush_sw_we got %b want 0", dm_write);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || mem[9] !== 32'h01020304) begin
      fails++; $display("[TB] FAIL flush_sw got v=%b mem=%h want 0/01020304", wb_valid, mem[9]);
    end
    preload(16, 32'hAAAAAAAA);
    present(0, 1, 2'd1, 0, 32'h42, 32'h00001234, 5'd0, 0, 0);
    refStore(32'h42, 2'd1, 32'h00001234);
    tick();
    present(1, 0, 2'd2, 0, 32'h40, 32'h0, 5'd9, 1, 1);
    #1;
    checks++;
    if (dm_write !== 1'b1 || dm_write_data !== 32'h1234AAAA || stall !== 1'b1) begin
      fails++; $display("[TB] FAIL sh_flush_merge got we=%b d=%h st=%b want 1/1234aaaa/1", dm_write, dm_write_data, stall);
    end
    tick();
    setIdle();
    checks++;
    if (mem[16] !== 32'h1234AAAA || wb_valid !== 1'b1 || mem[16] !== refMem[16]) begin
      fails++; $display("[TB] FAIL sh_flush_done got mem=%h v=%b want 1234aaaa/1", mem[16], wb_valid);
    end
  endtask

  task automatic test_random;
    logic        rdI, wrI, unsI, regW, flI, mis, isMem;
    logic [1:0]  sz;
    logic [31:0] addr, wd, expData;
    logic [4:0]  rdReg;
    int          kind;
    for (int n = 0; n < 80; n++) begin
      kind  = $urandom_range(0, 4);
      rdI   = (kind == 0 || kind == 1 || kind == 4);
      wrI   = (kind == 2 || kind == 3 || kind == 4);
      sz    = 2'($urandom_range(0, 2));
      unsI  = 1'($urandom_range(0, 1));
      regW  = 1'($urandom_range(0, 1));
      flI   = ($urandom_range(0, 7) == 0);
      addr  = 32'($urandom_range(0, 255));
      wd    = $urandom;
      rdReg = 5'($urandom_range(0, 31));
      isMem = rdI | wrI;
      mis   = isMem && ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00));
      present(rdI, wrI, sz, unsI, addr, wd, rdReg, regW, flI);
      #1;
      checks++;
      if (dm_write !== (!flI && !mis && wrI && sz == 2'd2) || dm_address !== {addr[31:2], 2'b00} || stall !== 1'b0) begin
        fails++; $display("[TB] FAIL rnd_port n=%0d got we=%b a=%h st=%b addr=%h", n, dm_write, dm_address, stall, addr);
      end
      expData = (rdI && !wrI) ? refLoad(addr, sz, unsI) : addr;
      if (!flI && !mis && wrI) refStore(addr, sz, wd);
      tick();
      if (!flI && !mis && wrI && sz != 2'd2) begin
        present(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'd2, 0, $urandom, $urandom, 5'd1, 1, 1'($urandom_range(0, 1)));
        #1;
        checks++;
        if (stall !== 1'b1 || dm_write !== 1'b1 || dm_address !== {addr[31:2], 2'b00} ||
            dm_write_data !== refMem[addr[7:2]] || wb_valid !== 1'b0) begin
          fails++; $display("[TB] FAIL rnd_merge n=%0d got st=%b we=%b a=%h d=%h v=%b want d=%h", n, stall, dm_write, dm_address, dm_write_data, wb_valid, refMem[addr[7:2]]);
        end
        tick();
        expData = addr;
      end
      checks++;
      if (flI) begin
        if (wb_valid !== 1'b0 || misalign_err !== 1'b0) begin
          fails++; $display("[TB] FAIL rnd_flush n=%0d got v=%b err=%b want 0/0", n, wb_valid, misalign_err);
        end
      end else if (mis) begin
        if (wb_valid !== 1'b0 || misalign_err !== 1'b1 || misalign_addr !== addr) begin
          fails++; $display("[TB] FAIL rnd_mis n=%0d got v=%b err=%b a=%h want 0/1/%h", n, wb_valid, misalign_err, misalign_addr, addr);
        end
      end else begin
        if (wb_valid !== 1'b1 || misalign_err !== 1'b0 || wb_reg_write !== (regW && !wrI) ||
            (!(wrI && sz != 2'd2) && (wb_rd !== rdReg || wb_data !== expData)) || mem[addr[7:2]] !== refMem[addr[7:2]]) begin
          fails++; $display("[TB] FAIL rnd_wb n=%0d got v=%b rw=%b rd=%0d d=%h mem=%h want rd=%0d d=%h mem=%h", n, wb_valid, wb_reg_write, wb_rd, wb_data, mem[addr[7:2]], rdReg, expData, refMem[addr[7:2]]);
        end
      end
      setIdle();
    end
  endtask

  task automatic test_reset_in_merge;
    preload(20, 32'h55555555);
    present(0, 1, 2'd0, 0, 32'h50, 32'h00000000, 5'd6, 0, 0);
    tick();
    setIdle();
    #1;
    checks++;
    if (stall !== 1'b1 || dm_write !== 1'b1) begin
      fails++; $display("[TB] FAIL rst_merge_pre got st=%b we=%b want 1/1", stall, dm_write);
    end
    reset = 0;
    #1;
    checks++;
    if (dm_write !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || misalign_err !== 1'b0 ||
        wb_rd !== 5'd0 || wb_data !== 32'd0 || misalign_addr !== 32'd0) begin
      fails++; $display("[TB] FAIL rst_merge_out got we=%b st=%b v=%b rd=%0d d=%h ma=%h want all zero", dm_write, stall, wb_valid, wb_rd, wb_data, misalign_addr);
    end
    tick();
    checks++;
    if (mem[20] !== 32'h55555555 || dm_write !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_merge_mem got mem=%h we=%b want 55555555/0", mem[20], dm_write);
    end
    reset = 1;
    tick();
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_merge_after got st=%b v=%b want 0/0", stall, wb_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'd0;
      refMem[i] = 32'd0;
    end
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_load_extension();
    test_misalign();
    test_flush();
    test_random();
    test_reset_in_merge();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
